// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer: each word is steered by up_sel into one of
// four 2-deep output FIFOs, each with a wrapping delivered-word counter.
module stream_demux_1_4 #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic [1:0]       up_sel,
    output logic [3:0]       down_valid,
    input  logic [3:0]       down_ready,
    output logic [W-1:0]     d0,
    output logic [W-1:0]     d1,
    output logic [W-1:0]     d2,
    output logic [W-1:0]     d3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [3:0][W-1:0]     head_q;
    logic [3:0][W-1:0]     tail_q;
    logic [3:0][1:0]       occ_q;
    logic [3:0][CNT_W-1:0] cnt_q;
    logic [3:0]            full;
    logic [3:0]            push;
    logic [3:0]            pop;

    // up_ready looks only at registered occupancy, so a full FIFO stays closed
    // even while it pops: no combinational ready-to-ready path.
    assign up_ready = !rst && !full[up_sel];

    for (genvar i = 0; i < 4; i++) begin : g_out
        assign full[i]       = (occ_q[i] == 2'd2);
        assign down_valid[i] = (occ_q[i] != 2'd0);
        assign push[i]       = up_valid && up_ready && (up_sel == 2'(i));
        assign pop[i]        = down_valid[i] && down_ready[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                occ_q[i]  <= 2'd0;
                cnt_q[i]  <= '0;
            end else begin
                if (pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                case (occ_q[i])
                    2'd0: begin
                        if (push[i]) begin
                            head_q[i] <= up_data;
                            occ_q[i]  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push[i] && pop[i]) begin
                            head_q[i] <= up_data;
                        end else if (push[i]) begin
                            tail_q[i] <= up_data;
                            occ_q[i]  <= 2'd2;
                        end else if (pop[i]) begin
                            occ_q[i]  <= 2'd0;
                        end
                    end
                    default: begin
                        // Full: no push can be accepted here, only a pop.
                        if (pop[i]) begin
                            head_q[i] <= tail_q[i];
                            occ_q[i]  <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign d0   = head_q[0];
    assign d1   = head_q[1];
    assign d2   = head_q[2];
    assign d3   = head_q[3];
    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4: routing, backpressure, push/pop overlap,
// full-FIFO bubble, counter wrap and mid-operation reset.
module tb_stream_demux_1_4;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             up_valid;
    logic             up_ready;
    logic [W-1:0]     up_data;
    logic [1:0]       up_sel;
    logic [3:0]       down_valid;
    logic [3:0]       down_ready;
    logic [W-1:0]     d0, d1, d2, d3;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    int n_checks = 0;
    int n_errors = 0;

    stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
        .down_valid(down_valid), .down_ready(down_ready),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving the sample point 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
        up_valid = v;
        up_sel   = s;
        up_data  = d;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up_valid = 1'b0;
        down_ready = 4'h0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; up_sel = 2'd0; up_data = '0; down_ready = 4'h0;
        tick();
        tick();
        chk("rst_dv", down_valid, 4'h0);
        chk("rst_ready", up_ready, 0);
        chk("rst_d0", d0, 0);
        chk("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
        rst = 1'b0;
        #1;

        // Basic routing
        down_ready = 4'hF;
        drive(1, 2'd0, 4'ha);
        chk("rt_ready0", up_ready, 1);
        tick();
        chk("rt_dv0", down_valid, 4'b0001); chk("rt_d0", d0, 4'ha);
        drive(1, 2'd1, 4'hb); tick();
        chk("rt_dv1", down_valid, 4'b0010); chk("rt_d1", d1, 4'hb);
        drive(1, 2'd2, 4'hc); tick();
        chk("rt_dv2", down_valid, 4'b0100); chk("rt_d2", d2, 4'hc);
        drive(1, 2'd3, 4'hd); tick();
        chk("rt_dv3", down_valid, 4'b1000); chk("rt_d3", d3, 4'hd);
        drive(0, 2'bxx, 4'h0); tick();
        chk("rt_dv_end", down_valid, 4'h0);
        chk("rt_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);

        // Backpressure on output 0
        do_reset();
        down_ready = 4'b1110;
        drive(1, 2'd0, 4'h1); tick();
        chk("bp_d0_first", d0, 4'h1);
        drive(1, 2'd0, 4'h2);
        chk("bp_ready_occ1", up_ready, 1);
        tick();
        drive(1, 2'd0, 4'h3);
        chk("bp_ready_full", up_ready, 0);
        drive(0, 2'd0, 4'h3); tick();
        drive(1, 2'd1, 4'h7);
        chk("bp_ready_sel1", up_ready, 1);
        tick();
        chk("bp_dv1", down_valid, 4'b0011); chk("bp_d1", d1, 4'h7);
        drive(1, 2'd0, 4'h3);
        chk("bp_ready_still_full", up_ready, 0);
        tick();
        chk("bp_dv_after7", down_valid, 4'b0001); chk("bp_cnt1", cnt1, 1);
        down_ready = 4'hF; #1;
        chk("bp_d0_1", d0, 4'h1);
        chk("bp_bubble", up_ready, 0);
        tick();
        chk("bp_d0_2", d0, 4'h2); chk("bp_ready_open", up_ready, 1);
        tick();
        drive(0, 2'd0, 4'h0);
        chk("bp_d0_3", d0, 4'h3); chk("bp_dv0_3", down_valid, 4'b0001);
        tick();
        chk("bp_dv_end", down_valid, 4'h0);
        chk("bp_cnt0", cnt0, 3); chk("bp_cnt1_end", cnt1, 1);

        // Simultaneous push and pop at occupancy 1
        do_reset();
        drive(1, 2'd2, 4'h5); tick();
        drive(0, 2'd2, 4'h0);
        chk("pp_d2_5", d2, 4'h5);
        down_ready = 4'b0100;
        drive(1, 2'd2, 4'h6);
        chk("pp_ready", up_ready, 1);
        tick();
        drive(0, 2'd0, 4'h0);
        down_ready = 4'h0; #1;
        chk("pp_d2_6", d2, 4'h6); chk("pp_dv", down_valid, 4'b0100); chk("pp_cnt2", cnt2, 1);
        down_ready = 4'b0100; tick();
        chk("pp_occ1_drained", down_valid, 4'h0); chk("pp_cnt2_end", cnt2, 2);

        // Full output plus pop: one-cycle bubble
        do_reset();
        drive(1, 2'd3, 4'h1); tick();
        drive(1, 2'd3, 4'h2); tick();
        down_ready = 4'b1000;
        drive(1, 2'd3, 4'h8);
        chk("fb_ready_full", up_ready, 0); chk("fb_d3_1", d3, 4'h1);
        tick();
        chk("fb_ready_next", up_ready, 1); chk("fb_d3_2", d3, 4'h2);
        tick();
        drive(0, 2'd0, 4'h0);
        chk("fb_d3_8", d3, 4'h8); chk("fb_dv3", down_valid, 4'b1000);
        tick();
        chk("fb_cnt3", cnt3, 3); chk("fb_dv_end", down_valid, 4'h0);

        // Counter wrap on output 1
        do_reset();
        down_ready = 4'hF;
        for (int k = 0; k < 255; k++) begin
            drive(1, 2'd1, W'(k));
            tick();
        end
        drive(0, 2'd1, 4'h0);
        tick();
        chk("wr_cnt1_255", cnt1, 255);
        chk("wr_others", {cnt3, cnt2, cnt0}, 0);
        drive(1, 2'd1, 4'hc); tick();
        drive(0, 2'd1, 4'h0);
        chk("wr_d1", d1, 4'hc);
        tick();
        chk("wr_cnt1_0", cnt1, 0);
        chk("wr_others_end", {cnt3, cnt2, cnt0}, 0);

        // Reset in the middle of operation
        do_reset();
        drive(1, 2'd0, 4'h1); tick();
        drive(1, 2'd0, 4'h2); tick();
        drive(1, 2'd2, 4'h4); tick();
        drive(0, 2'd0, 4'h0);
        down_ready = 4'h1; tick();
        chk("mr_pre_dv", down_valid, 4'b0101); chk("mr_pre_cnt0", cnt0, 1);
        down_ready = 4'h0;
        rst = 1'b1;
        drive(1, 2'd1, 4'hf);
        chk("mr_ready_in_rst", up_ready, 0);
        tick();
        chk("mr_dv", down_valid, 4'h0);
        chk("mr_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
        chk("mr_ready", up_ready, 0);
        chk("mr_d0_clr", d0, 0);
        rst = 1'b0;
        drive(1, 2'd0, 4'h9); tick();
        drive(0, 2'd0, 4'h0);
        chk("mr_d0_9", d0, 4'h9); chk("mr_dv_9", down_valid, 4'b0001);
        down_ready = 4'hF; tick();
        chk("mr_no_stale", down_valid, 4'h0); chk("mr_cnt0", cnt0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
